// File: rtl/ifetch_pkg.sv
// Shared constants for the instruction fetch unit.
// State encoding, reset vector and the word delivered on a fault.
package ifetch_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   localparam logic [31:0] RESET_VECTOR = 32'h00400020;
   localparam logic [31:0] NOP_WORD     = 32'h00000000;

   function automatic logic is_aligned(input logic [31:0] a);
      return (a[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/instr_fetch_32_if.sv
// Bundle of PC, memory and decode handshakes around the fetch unit.
// master = fetch unit, slave = PC/memory/decode environment.
interface instr_fetch_32_if;

   logic [31:0] pc_in;
   logic        pc_valid;
   logic        pc_ready;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        imem_err;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        fetch_fault;
   logic        flush;
   logic [31:0] fetch_count;

   modport master (
      input  pc_in, pc_valid, imem_ack, imem_rdata, imem_err,
      input  instr_ready, flush,
      output pc_ready, imem_req, imem_addr, instr, instr_pc,
      output instr_valid, fetch_fault, fetch_count
   );

   modport slave (
      output pc_in, pc_valid, imem_ack, imem_rdata, imem_err,
      output instr_ready, flush,
      input  pc_ready, imem_req, imem_addr, instr, instr_pc,
      input  instr_valid, fetch_fault, fetch_count
   );

endinterface

// File: rtl/instr_fetch_32.sv
// Single-outstanding instruction fetch: PC in, memory read, word out.
// Misaligned PCs and bus errors are delivered as faulted NOP words.
module instr_fetch_32
   import ifetch_pkg::*;
#(
   // reset value of the delivered-instruction counter
   parameter logic [31:0] COUNT_RST = 32'h00000000
)(
   input  logic             clk,
   input  logic             reset,
   instr_fetch_32_if.master bus
);

   logic [1:0]  r_state;
   logic [31:0] r_addr;
   logic [31:0] r_instr;
   logic [31:0] r_pc;
   logic        r_fault;
   logic [31:0] r_count;
   logic        r_discard;

   logic        w_pc_ready;
   logic        w_pc_hs;
   logic        w_drop_ack;

   // accept a new PC when idle or when the held word leaves this cycle
   always_comb begin
      w_pc_ready = 1'b0;
      if (!bus.flush)
         w_pc_ready = (r_state == ST_IDLE) ||
                      ((r_state == ST_HOLD) && bus.instr_ready);
   end

   assign w_pc_hs    = bus.pc_valid && w_pc_ready;
   assign w_drop_ack = r_discard || bus.flush;

   // fetch state machine, output word registers and delivery counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= ST_IDLE;
         r_addr    <= RESET_VECTOR;
         r_instr   <= NOP_WORD;
         r_pc      <= RESET_VECTOR;
         r_fault   <= 1'b0;
         r_count   <= COUNT_RST;
         r_discard <= 1'b0;
      end else begin
         unique case (r_state)
            ST_IDLE: ;
            ST_REQ: begin
               if (bus.imem_ack) begin
                  if (w_drop_ack) begin
                     r_state   <= ST_IDLE;
                     r_discard <= 1'b0;
                  end else begin
                     r_state <= ST_HOLD;
                     r_instr <= bus.imem_err ? NOP_WORD
                                             : bus.imem_rdata;
                     r_fault <= bus.imem_err;
                  end
               end else if (bus.flush) begin
                  r_discard <= 1'b1;
               end
            end
            ST_HOLD: begin
               if (bus.flush) begin
                  r_state <= ST_IDLE;
               end else if (bus.instr_ready) begin
                  r_count <= r_count + 32'd1;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase

         // a handshake overrides the IDLE exit chosen above
         if (w_pc_hs) begin
            r_pc <= bus.pc_in;
            if (is_aligned(bus.pc_in)) begin
               r_addr  <= bus.pc_in;
               r_state <= ST_REQ;
            end else begin
               r_instr <= NOP_WORD;
               r_fault <= 1'b1;
               r_state <= ST_HOLD;
            end
         end
      end
   end

   assign bus.pc_ready    = w_pc_ready;
   assign bus.imem_req    = (r_state == ST_REQ);
   assign bus.imem_addr   = r_addr;
   assign bus.instr       = r_instr;
   assign bus.instr_pc    = r_pc;
   assign bus.instr_valid = (r_state == ST_HOLD);
   assign bus.fetch_fault = r_fault;
   assign bus.fetch_count = r_count;

endmodule
